uart_rx: RTL and testbench

Receive stage of the UART: recovers 8N1 frames from the serial line driven by the transmit stage or an external device and presents each byte as a one-cycle strobe. It uses an oversampling tick from the shared baud generator, synchronises the asynchronous line, validates the start bit at mid-bit and checks the stop bit. Its parallel output feeds the receive-side consumer (FIFO or register interface).

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation,
// LSB-first data sampling on an oversample tick, stop-bit check and break hold-off.
module uart_rx #(
   parameter int OS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int TW = (OS > 2) ? $clog2(OS) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   localparam logic [TW-1:0] HALF_M1 = TW'(OS / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(OS - 1);

   logic          rx_meta_q, rx_s_q;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      bcnt_d      = bcnt_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               tcnt_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else if (tcnt_q == HALF_M1) begin
                  tcnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = S_DATA;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tcnt_q == FULL_M1) begin
                  shreg_d = {rx_s_q, shreg_q[7:1]};
                  tcnt_d  = '0;
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tcnt_q == FULL_M1) begin
                  tcnt_d = '0;
                  if (rx_s_q) begin
                     data_d  = shreg_q;
                     valid_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         S_BREAK: begin
            // Held-low line must release before a new start edge is accepted.
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tcnt_q      <= '0;
         bcnt_q      <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         bcnt_q      <= bcnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame/glitch/break stimulus against a queue-based model of expected
// receiver pulses, with directed frames pinning the model to literal values.
module tb_uart_rx;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   logic       div = 1'b0;

   int total = 0;
   int bad = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int busy_cnt = 0;
   bit chk_en = 1'b0;
   bit prev_pulse = 1'b0;

   // Model: outcome of every frame sent, in order (1 = framing error), and the
   // byte the data output must currently hold.
   bit         exp_err[$];
   logic [7:0] exp_byte[$];
   logic [7:0] exp_data = 8'h00;

   uart_rx #(.OS(OS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // One tick every two clocks.
   always @(posedge clk) begin
      div  <= ~div;
      tick <= (div == 1'b0);
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_pulse = 1'b0;
      end else if (chk_en) begin
         if (busy) busy_cnt++;
         if (valid || frame_err) begin
            chk("pulse_exclusive", {31'd0, valid && frame_err}, 32'd0);
            chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (valid) valid_cnt++;
            if (frame_err) ferr_cnt++;
            if (exp_err.size() == 0) begin
               chk("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
            end else begin
               bit         e;
               logic [7:0] b;
               e = exp_err.pop_front();
               b = exp_byte.pop_front();
               chk("pulse_kind", {30'd0, valid, frame_err}, e ? 32'd1 : 32'd2);
               if (!e) exp_data = b;
            end
         end
         chk("data", {24'd0, data}, {24'd0, exp_data});
         prev_pulse = valid || frame_err;
      end
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (tick !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      exp_err.push_back(!stop);
      exp_byte.push_back(b);
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_ticks(OS);
      end
      rx = stop;
      wait_ticks(OS);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_err.size() != 0 && n < 8 * OS) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(name, exp_err.size(), 32'd0);
      exp_err.delete();
      exp_byte.delete();
   endtask

   task automatic glitch(input int g);
      busy_cnt = 0;
      rx = 1'b0;
      wait_ticks(g);
      rx = 1'b1;
      wait_ticks(OS);
      chk("glitch_busy_short", {31'd0, busy_cnt < 16}, 32'd1);
      chk("glitch_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic break_frame(input logic [7:0] b, input int hold_bits);
      send_frame(b, 1'b0);
      wait_ticks(OS * hold_bits);
      drain("break_pulse");
      chk("break_busy", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_ticks(2);
      chk("break_release", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // Reset state
      rx = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      wait_ticks(4);

      // Single frame
      send_frame(8'hA5, 1'b1);
      drain("a5_pulse");
      chk("a5_data", {24'd0, data}, 32'h0000_00A5);
      chk("a5_busy", {31'd0, busy}, 32'd0);
      chk("a5_count", valid_cnt, 32'd1);

      // Glitch
      glitch(5);

      // Framing error with long break, then recovery
      break_frame(8'h3C, 20);
      chk("ferr_data_kept", {24'd0, data}, 32'h0000_00A5);
      chk("ferr_count", ferr_cnt, 32'd1);
      wait_ticks(OS);
      send_frame(8'h5A, 1'b1);
      drain("5a_pulse");
      chk("5a_data", {24'd0, data}, 32'h0000_005A);

      // Back-to-back
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      drain("b2b_pulse");
      chk("b2b_data", {24'd0, data}, 32'h0000_0081);
      chk("b2b_count", valid_cnt, 32'd5);
      chk("b2b_ferr", ferr_cnt, 32'd1);

      // Randomised mix
      for (int it = 0; it < 40; it++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel <= 5) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            drain("rand_pulse");
            chk("rand_idle", {31'd0, busy}, 32'd0);
            wait_ticks($urandom_range(0, OS));
         end else if (sel <= 7) begin
            break_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3));
            wait_ticks($urandom_range(0, OS));
         end else begin
            glitch($urandom_range(1, 5));
         end
      end

      // Reset mid-frame during data bit 4 of 0xC3
      rx = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 4; i++) begin
         rx = 8'hC3 >> i;
         wait_ticks(OS);
      end
      rx = 1'b0;
      wait_ticks(OS / 2);
      rst_n = 1'b0;
      rx = 1'b1;
      exp_data = 8'h00;
      exp_err.delete();
      exp_byte.delete();
      #1;
      chk("midrst_data", {24'd0, data}, 32'd0);
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ticks(OS);
      chk("midrst_idle", {31'd0, busy}, 32'd0);
      send_frame(8'h96, 1'b1);
      drain("96_pulse");
      chk("96_data", {24'd0, data}, 32'h0000_0096);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
